// File: rtl/data_memory_controller.sv
// Load/store sequencer between the memory stage and a req/ack data bus.
// Holds the pipeline while an access is outstanding and returns extended load data.
module data_memory_controller #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        access_fault,
  output logic        bus_error,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [1:0]  dbg_state
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic [2:0]    f3_q;
  logic [1:0]    off_q;

  logic          req_valid;
  logic          legal_f3;
  logic          misaligned;
  logic          fault;
  logic          accept;
  logic          timeout_hit;
  logic [3:0]    be_n;
  logic [31:0]   wdata_n;
  logic [31:0]   rd_shift;
  logic [31:0]   load_ext;

  assign dbg_state = state;

  // Request decode: a store takes priority when both strobes are high.
  assign req_valid = req_read | req_write;

  always_comb begin
    legal_f3 = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: legal_f3 = 1'b1;
      3'b100, 3'b101:         legal_f3 = ~req_write;
      default:                legal_f3 = 1'b0;
    endcase
  end

  assign misaligned = ((req_funct3[1:0] == 2'b01) & req_addr[0]) |
                      ((req_funct3[1:0] == 2'b10) & (req_addr[1:0] != 2'b00));
  assign fault      = ~legal_f3 | misaligned;

  assign accept       = (state == IDLE) & req_valid & ~fault;
  assign access_fault = (state == IDLE) & req_valid & fault;
  assign stall        = accept | (state == ACCESS);
  assign timeout_hit  = (state == ACCESS) & ~mem_ack & (cnt == CNT_LAST);

  // Lane placement of store data and byte enables.
  always_comb begin
    be_n    = 4'b1111;
    wdata_n = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        be_n    = 4'b0001 << req_addr[1:0];
        wdata_n = {24'b0, req_wdata[7:0]} << {req_addr[1:0], 3'b000};
      end
      2'b01: begin
        be_n    = 4'b0011 << req_addr[1:0];
        wdata_n = {16'b0, req_wdata[15:0]} << {req_addr[1:0], 3'b000};
      end
      default: begin
        be_n    = 4'b1111;
        wdata_n = req_wdata;
      end
    endcase
  end

  // Word accesses are always aligned, so the shift is a no-op for them.
  assign rd_shift = mem_rdata >> {off_q, 3'b000};

  always_comb begin
    load_ext = rd_shift;
    case (f3_q)
      3'b000:  load_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  load_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  load_ext = {24'b0, rd_shift[7:0]};
      3'b101:  load_ext = {16'b0, rd_shift[15:0]};
      default: load_ext = rd_shift;
    endcase
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = ACCESS;
      ACCESS:  if (mem_ack || timeout_hit) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'b0;
      mem_wdata  <= 32'b0;
      mem_be     <= 4'b0;
      load_data  <= 32'b0;
      load_valid <= 1'b0;
      bus_error  <= 1'b0;
      cnt        <= '0;
      f3_q       <= 3'b0;
      off_q      <= 2'b0;
    end else begin
      load_valid <= 1'b0;
      bus_error  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            mem_req   <= 1'b1;
            mem_we    <= req_write;
            mem_addr  <= {req_addr[31:2], 2'b00};
            mem_wdata <= wdata_n;
            mem_be    <= be_n;
            f3_q      <= req_funct3;
            off_q     <= req_addr[1:0];
            cnt       <= '0;
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            mem_req    <= 1'b0;
            load_valid <= ~mem_we;
            if (!mem_we) load_data <= load_ext;
          end else if (timeout_hit) begin
            mem_req    <= 1'b0;
            bus_error  <= 1'b1;
            load_data  <= 32'b0;
            load_valid <= ~mem_we;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_controller.sv
// Directed bench for data_memory_controller: loads, stores, faults, timeout
// and asynchronous reset during an access, with a small bus responder.
module tb_data_memory_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_read, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid, access_fault, bus_error;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  // Results captured by do_access.
  int          r_stall, r_acc;
  logic        r_lv, r_berr, r_unstable, r_done, r_we;
  logic [31:0] r_data, r_addr, r_wdata;
  logic [3:0]  r_be;

  data_memory_controller #(.TIMEOUT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_read     (req_read),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_funct3   (req_funct3),
    .stall        (stall),
    .load_data    (load_data),
    .load_valid   (load_valid),
    .access_fault (access_fault),
    .bus_error    (bus_error),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_be       (mem_be),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack),
    .dbg_state    (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Presents one request and acts as the bus: acks in ACCESS cycle delay+1
  // (delay < 0 means never). Returns in the DONE cycle with requests dropped.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [2:0] f3,
                           input int delay, input logic [31:0] rdata);
    r_stall = 0; r_acc = 0; r_lv = 1'b0; r_berr = 1'b0; r_unstable = 1'b0;
    r_done = 1'b0; r_data = 32'b0; r_we = 1'b0; r_addr = 32'b0; r_wdata = 32'b0;
    r_be = 4'b0;
    @(negedge clk);
    req_read = rd; req_write = wr; req_addr = addr; req_wdata = wd; req_funct3 = f3;
    for (int i = 0; i < 40 && !r_done; i++) begin
      #1;
      if (load_valid) begin r_lv = 1'b1; r_data = load_data; end
      if (bus_error) r_berr = 1'b1;
      if (i > 0 && !stall) begin
        r_done = 1'b1;
        req_read = 1'b0; req_write = 1'b0; mem_ack = 1'b0;
      end else begin
        if (stall) r_stall++;
        if (mem_req) begin
          if (r_acc == 0) begin
            r_we = mem_we; r_addr = mem_addr; r_wdata = mem_wdata; r_be = mem_be;
          end else if (r_we !== mem_we || r_addr !== mem_addr ||
                       r_wdata !== mem_wdata || r_be !== mem_be) begin
            r_unstable = 1'b1;
          end
          r_acc++;
          mem_ack   = (r_acc == delay + 1);
          mem_rdata = rdata;
        end else begin
          mem_ack = 1'b0;
        end
        @(negedge clk);
      end
    end
    if (!r_done) begin
      check("access_done", 32'(r_done), 32'd1);
      req_read = 1'b0; req_write = 1'b0; mem_ack = 1'b0;
    end
  endtask

  task automatic fault_case(input string tag, input logic rd, input logic wr,
                            input logic [31:0] addr, input logic [2:0] f3);
    @(negedge clk);
    req_read = rd; req_write = wr; req_addr = addr; req_wdata = 32'hCAFE_F00D;
    req_funct3 = f3;
    #1;
    check({tag, "_fault"}, 32'(access_fault), 32'd1);
    check({tag, "_stall"}, 32'(stall), 32'd0);
    @(negedge clk);
    #1;
    check({tag, "_req"}, 32'(mem_req), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'd0);
    req_read = 1'b0; req_write = 1'b0;
    #1;
    check({tag, "_clr"}, 32'(access_fault), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    req_read = 1'b0; req_write = 1'b0; req_addr = 32'b0; req_wdata = 32'b0;
    req_funct3 = 3'b0; mem_rdata = 32'b0; mem_ack = 1'b0;

    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_be", 32'(mem_be), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_load_data", load_data, 32'd0);
    check("rst_load_valid", 32'(load_valid), 32'd0);
    check("rst_bus_error", 32'(bus_error), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_fault", 32'(access_fault), 32'd0);
    rst = 1'b0;

    // LW, ack in the first ACCESS cycle
    do_access(1'b1, 1'b0, 32'h100, 32'h0, 3'b010, 0, 32'hDEAD_BEEF);
    check("lw_addr", r_addr, 32'h100);
    check("lw_be", 32'(r_be), 32'hF);
    check("lw_we", 32'(r_we), 32'd0);
    check("lw_stall", 32'(r_stall), 32'd2);
    check("lw_acc", 32'(r_acc), 32'd1);
    check("lw_valid", 32'(r_lv), 32'd1);
    check("lw_data", r_data, 32'hDEAD_BEEF);

    // LB / LBU from the top byte lane
    do_access(1'b1, 1'b0, 32'h103, 32'h0, 3'b000, 0, 32'h8012_3456);
    check("lb_be", 32'(r_be), 32'h8);
    check("lb_addr", r_addr, 32'h100);
    check("lb_data", r_data, 32'hFFFF_FF80);
    check("lb_stall", 32'(r_stall), 32'd2);
    do_access(1'b1, 1'b0, 32'h103, 32'h0, 3'b100, 0, 32'h8012_3456);
    check("lbu_be", 32'(r_be), 32'h8);
    check("lbu_data", r_data, 32'h0000_0080);

    // LH upper half, LHU lower half
    do_access(1'b1, 1'b0, 32'h102, 32'h0, 3'b001, 0, 32'h8001_1234);
    check("lh_be", 32'(r_be), 32'hC);
    check("lh_data", r_data, 32'hFFFF_8001);
    do_access(1'b1, 1'b0, 32'h100, 32'h0, 3'b101, 0, 32'h1234_F00D);
    check("lhu_be", 32'(r_be), 32'h3);
    check("lhu_data", r_data, 32'h0000_F00D);

    // SH with ack delayed 3 cycles (lands on the last cycle before timeout)
    do_access(1'b0, 1'b1, 32'h202, 32'h1234_ABCD, 3'b001, 3, 32'h0);
    check("sh_we", 32'(r_we), 32'd1);
    check("sh_be", 32'(r_be), 32'hC);
    check("sh_addr", r_addr, 32'h200);
    check("sh_wdata", r_wdata, 32'hABCD_0000);
    check("sh_stall", 32'(r_stall), 32'd5);
    check("sh_acc", 32'(r_acc), 32'd4);
    check("sh_valid", 32'(r_lv), 32'd0);
    check("sh_berr", 32'(r_berr), 32'd0);
    check("sh_stable", 32'(r_unstable), 32'd0);

    // SB into lane 1, ack after one extra cycle
    do_access(1'b0, 1'b1, 32'h101, 32'h1234_56EF, 3'b000, 1, 32'h0);
    check("sb_be", 32'(r_be), 32'h2);
    check("sb_wdata", r_wdata, 32'h0000_EF00);
    check("sb_stall", 32'(r_stall), 32'd3);

    // Illegal accesses
    fault_case("lw_mis", 1'b1, 1'b0, 32'h101, 3'b010);
    fault_case("sh_mis", 1'b0, 1'b1, 32'h201, 3'b001);
    fault_case("f3_011", 1'b1, 1'b0, 32'h100, 3'b011);
    fault_case("st_f3_100", 1'b1, 1'b1, 32'h100, 3'b100);

    // Stray ack while idle
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    check("stray_valid", 32'(load_valid), 32'd0);
    check("stray_state", 32'(dbg_state), 32'd0);
    check("stray_data", load_data, 32'h0000_F00D);

    // Timeout: no ack at all
    do_access(1'b1, 1'b0, 32'h400, 32'h0, 3'b010, -1, 32'h0);
    check("to_acc", 32'(r_acc), 32'd4);
    check("to_stall", 32'(r_stall), 32'd5);
    check("to_berr", 32'(r_berr), 32'd1);
    check("to_valid", 32'(r_lv), 32'd1);
    check("to_data", r_data, 32'd0);
    @(negedge clk);
    #1;
    check("to_idle", 32'(dbg_state), 32'd0);
    check("to_berr_pulse", 32'(bus_error), 32'd0);

    // Reset in the second ACCESS cycle, then a late ack
    @(negedge clk);
    req_read = 1'b1; req_addr = 32'h300; req_funct3 = 3'b010;
    @(negedge clk);
    #1;
    check("rr_req_on", 32'(mem_req), 32'd1);
    @(negedge clk);
    rst = 1'b1; req_read = 1'b0;
    #1;
    check("rr_req_off", 32'(mem_req), 32'd0);
    check("rr_stall", 32'(stall), 32'd0);
    check("rr_be", 32'(mem_be), 32'd0);
    check("rr_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    check("late_valid", 32'(load_valid), 32'd0);
    check("late_req", 32'(mem_req), 32'd0);
    check("late_data", load_data, 32'd0);
    check("late_state", 32'(dbg_state), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_memory_controller.md
# data_memory_controller

Sequencer between the pipeline's memory stage and the data memory bus. Accepts one load or store per instruction, drives a req/ack memory port with byte lanes, and stalls the pipeline until the access completes. Returns sign- or zero-extended load data to writeback. Flags misaligned or unsupported accesses and bus timeouts. Sits between the EX/MEM register outputs and the data RAM or bus interconnect.

## Interface
- TIMEOUT, 255: maximum ACCESS cycles to wait for `mem_ack` before aborting; must be ≥1.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_read  in  1  load request (MemRead).
- req_write  in  1  store request (MemWrite).
- req_addr  in  32  byte address (ALU result).
- req_wdata  in  32  store data (rs2 value).
- req_funct3  in  3  access size and signedness (RV32I encoding).
- stall  out  1  freeze upstream pipeline registers.
- load_data  out  32  extended load result, registered.
- load_valid  out  1  one-cycle pulse; `load_data` is valid.
- access_fault  out  1  misaligned or unsupported funct3; combinational, IDLE only.
- bus_error  out  1  one-cycle pulse on timeout.
- mem_req  out  1  bus request, registered.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word address (`req_addr` with bits [1:0] forced to 0).
- mem_wdata  out  32  store data shifted into the addressed lanes.
- mem_be  out  4  byte enables (bit i = byte lane i).
- mem_rdata  in  32  read data, valid when `mem_ack` = 1.
- mem_ack  in  1  one-cycle completion strobe.

## Operation
- States: IDLE, ACCESS, DONE.
- A request is valid when `req_read` or `req_write` is 1. If both are 1, the write wins.
- Legal funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- Any other funct3 is a fault.
- Alignment rules: a halfword needs addr[0]=0; a word needs addr[1:0]=00.
- IDLE, valid request, fault:
  - `access_fault`=1 and `stall`=0.
  - No bus access; stores are suppressed.
  - Stay in IDLE.
- IDLE, valid legal request:
  - `stall`=1.
  - Latch we, word address, lane-shifted wdata, be, funct3, addr[1:0].
  - Clear the timeout counter; go to ACCESS.
- Byte enables by size:
  - SB/LB/LBU: `mem_be` = 0001 << addr[1:0].
  - SH/LH/LHU: `mem_be` = 0011 << addr[1:0].
  - SW/LW: `mem_be` = 1111.
- Store data is the low byte/half/word of `req_wdata`, shifted left by 8·addr[1:0].
- ACCESS:
  - `mem_req`=1, `stall`=1; all `mem_*` outputs stay stable.
  - On `mem_ack`: for a read, select the lane and extend `mem_rdata` into `load_data`; go to DONE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT−1 without ack: pulse `bus_error` in the following cycle, set `load_data`=0, go to DONE.
- DONE:
  - `stall`=0.
  - `load_valid`=1 if the access was a read.
  - Inputs are ignored, because the same instruction is still presented.
  - Go unconditionally to IDLE.
- `mem_ack` arriving outside ACCESS is ignored.

## Timing
- Reset values: state=IDLE, and `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_be`, `load_data`, `load_valid`, `bus_error`, counter all 0. `stall`=0 and `access_fault`=0 while no request is present.
- `stall` is combinational: (IDLE & valid legal request) | ACCESS.
- Minimum access, request at cycle T:
  - T: IDLE, stall.
  - T+1: ACCESS, `mem_req`=1, ack arrives.
  - T+2: DONE, `load_valid`.
  - Total 2 stall cycles.
- An ack delayed by N cycles adds N stall cycles.
- Timeout case: at most TIMEOUT ACCESS cycles, then DONE with `bus_error`=1 and `load_valid`=1 for a read (data 0).
- Reset mid-access: asynchronous return to IDLE; `mem_req` drops without waiting for the clock; the access is abandoned with no `load_valid`.
- Back-to-back memory instructions: the next request is accepted in the IDLE cycle after DONE. Peak throughput is one access per 3 cycles.

## Test plan
- LW from 0x100, ack in first ACCESS cycle, `mem_rdata`=0xDEADBEEF → `mem_addr`=0x100, `mem_be`=1111, stall for 2 cycles, `load_data`=0xDEADBEEF with `load_valid` at T+2.
- LB from 0x103 (rdata 0x80xxxxxx), then LBU from the same address → `mem_be`=1000; LB gives 0xFFFFFF80, LBU gives 0x00000080.
- SH at 0x202 with `req_wdata`=0x1234ABCD, ack delayed 3 cycles → `mem_we`=1, `mem_be`=1100, `mem_wdata`[31:16]=0xABCD, 5 stall cycles, no `load_valid`.
- LW from 0x101; SH at 0x201; funct3=011 → `access_fault`=1, `stall`=0, `mem_req` never asserted.
- TIMEOUT=4, LW with no ack → 4 ACCESS cycles, then `bus_error`=1, `load_valid`=1, `load_data`=0, then IDLE.
- `rst` asserted in the second ACCESS cycle → `mem_req`, `stall`, `mem_be` go to 0 immediately; a late ack after reset is released is ignored.
